// File: rtl/esm_pkg.sv
// Shared types and sizing for the ESM issue scheduler family.
package esm_pkg;
  localparam int BS     = 32;
  localparam int REGNUM = 16;
  localparam int TAGW   = 32;
  localparam int IDXW   = $clog2(BS);
  localparam int REGW   = $clog2(REGNUM);
  localparam int CNTW   = IDXW + 1;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    WAIT   = 2'd1,
    ISSUED = 2'd2
  } entry_state_t;

  typedef struct packed {
    logic [REGW-1:0] rd;
    logic [REGW-1:0] rs1;
    logic [REGW-1:0] rs2;
    logic [TAGW-1:0] tag;
  } entry_t;
endpackage

// File: rtl/esm_age_select.sv
// Oldest-requester picker: age[k][j]=1 means entry j is older than entry k.
module esm_age_select #(
  parameter int N = 32,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [N-1:0]  age [N],
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx
);
  always_comb begin
    grant = '0;
    idx   = '0;
    // Ages form a total order over occupied entries, so at most one bit survives.
    for (int k = 0; k < N; k++) begin
      if (req[k] && ((age[k] & req) == '0)) grant[k] = 1'b1;
    end
    for (int k = 0; k < N; k++) begin
      if (grant[k]) idx = idx | IW'(k);
    end
  end
endmodule

// File: rtl/esm_issue_scheduler.sv
// Out-of-order issue window: tracks RAW/WAW/WAR dependencies and issues the oldest ready entry.
module esm_issue_scheduler
  import esm_pkg::*;
#(
  parameter int BS     = esm_pkg::BS,
  parameter int REGNUM = esm_pkg::REGNUM,
  parameter int TAGW   = esm_pkg::TAGW,
  localparam int IW    = $clog2(BS),
  localparam int RW    = $clog2(REGNUM),
  localparam int CW    = IW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [RW-1:0] in_rd,
  input  logic [RW-1:0] in_rs1,
  input  logic [RW-1:0] in_rs2,
  input  logic [TAGW-1:0] in_tag,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [IW-1:0] out_idx,
  output logic [RW-1:0] out_rd,
  output logic [RW-1:0] out_rs1,
  output logic [RW-1:0] out_rs2,
  output logic [TAGW-1:0] out_tag,
  input  logic          cmp_valid,
  input  logic [IW-1:0] cmp_idx,
  output logic [CW-1:0] count,
  output logic          err_cmp
);
  entry_state_t  state [BS];
  entry_t        ent   [BS];
  logic [BS-1:0] dep   [BS];
  logic [BS-1:0] age   [BS];

  logic [BS-1:0] free_vec, occ_vec, ready_vec, clr_mask, new_dep, new_age, grant;
  logic [IW-1:0] alloc_idx, age_idx, sel_idx, hold_idx;
  logic          hold_valid, cmp_hit, do_insert, do_issue;
  logic [CW-1:0] count_q;

  esm_age_select #(.N(BS)) u_age_select (
    .req   (ready_vec),
    .age   (age),
    .grant (grant),
    .idx   (age_idx)
  );

  always_comb begin
    free_vec  = '0;
    occ_vec   = '0;
    ready_vec = '0;
    for (int i = 0; i < BS; i++) begin
      free_vec[i]  = (state[i] == FREE);
      occ_vec[i]   = (state[i] != FREE);
      ready_vec[i] = (state[i] == WAIT) && (dep[i] == '0);
    end
    alloc_idx = '0;
    for (int i = BS - 1; i >= 0; i--) begin
      if (free_vec[i]) alloc_idx = IW'(i);
    end
    cmp_hit  = cmp_valid && (state[cmp_idx] == ISSUED);
    clr_mask = cmp_hit ? ({{(BS-1){1'b0}}, 1'b1} << cmp_idx) : '0;
    // A producer retiring this very edge must not leave a stale dependency behind.
    new_dep = '0;
    for (int j = 0; j < BS; j++) begin
      if (occ_vec[j] && !clr_mask[j]) begin
        if ((ent[j].rd != '0) && ((ent[j].rd == in_rs1) || (ent[j].rd == in_rs2)))
          new_dep[j] = 1'b1;
        if ((in_rd != '0) && (ent[j].rd == in_rd))
          new_dep[j] = 1'b1;
        if ((state[j] == WAIT) && (in_rd != '0) &&
            ((ent[j].rs1 == in_rd) || (ent[j].rs2 == in_rd)))
          new_dep[j] = 1'b1;
      end
    end
    new_age = occ_vec & ~clr_mask;
  end

  // A stalled pick is pinned so a newly-ready older entry cannot change the offer.
  assign sel_idx   = hold_valid ? hold_idx : age_idx;
  assign out_valid = |ready_vec;
  assign in_ready  = |free_vec;
  assign do_insert = in_valid && in_ready;
  assign do_issue  = out_valid && out_ready;
  assign out_idx   = sel_idx;
  assign out_rd    = ent[sel_idx].rd;
  assign out_rs1   = ent[sel_idx].rs1;
  assign out_rs2   = ent[sel_idx].rs2;
  assign out_tag   = ent[sel_idx].tag;
  assign count     = count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BS; i++) begin
        state[i] <= FREE;
        ent[i]   <= '0;
        dep[i]   <= '0;
        age[i]   <= '0;
      end
      count_q    <= '0;
      err_cmp    <= 1'b0;
      hold_valid <= 1'b0;
      hold_idx   <= '0;
    end else if (flush) begin
      for (int i = 0; i < BS; i++) begin
        state[i] <= FREE;
        dep[i]   <= '0;
        age[i]   <= '0;
      end
      count_q    <= '0;
      err_cmp    <= 1'b0;
      hold_valid <= 1'b0;
    end else begin
      err_cmp    <= cmp_valid && !cmp_hit;
      count_q    <= count_q + CW'(do_insert) - CW'(cmp_hit);
      hold_valid <= out_valid && !out_ready;
      hold_idx   <= sel_idx;
      for (int i = 0; i < BS; i++) begin
        dep[i] <= dep[i] & ~clr_mask;
        age[i] <= age[i] & ~clr_mask;
      end
      if (cmp_hit) state[cmp_idx] <= FREE;
      if (do_issue) state[sel_idx] <= ISSUED;
      if (do_insert) begin
        state[alloc_idx] <= WAIT;
        ent[alloc_idx]   <= '{rd: in_rd, rs1: in_rs1, rs2: in_rs2, tag: in_tag};
        dep[alloc_idx]   <= new_dep;
        age[alloc_idx]   <= new_age;
      end
    end
  end
endmodule

// File: tb/tb_esm_issue_scheduler.sv
// Directed scenarios for esm_issue_scheduler with an issue-order scoreboard.
module tb_esm_issue_scheduler;
  import esm_pkg::*;
  localparam int EW = IDXW + 3 * REGW + TAGW;

  logic            clk, rst_n, flush;
  logic            in_valid, in_ready;
  logic [REGW-1:0] in_rd, in_rs1, in_rs2;
  logic [TAGW-1:0] in_tag;
  logic            out_valid, out_ready;
  logic [IDXW-1:0] out_idx;
  logic [REGW-1:0] out_rd, out_rs1, out_rs2;
  logic [TAGW-1:0] out_tag;
  logic            cmp_valid;
  logic [IDXW-1:0] cmp_idx;
  logic [CNTW-1:0] count;
  logic            err_cmp;

  int checks = 0;
  int errors = 0;
  logic [EW-1:0] exp_q[$];
  logic [TAGW-1:0] t [8];

  esm_issue_scheduler dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_idx(out_idx),
    .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_tag(out_tag),
    .cmp_valid(cmp_valid), .cmp_idx(cmp_idx), .count(count), .err_cmp(err_cmp)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic insert(input logic [REGW-1:0] rd, rs1, rs2, input logic [TAGW-1:0] tag);
    in_valid = 1'b1; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_tag = tag;
    step();
    in_valid = 1'b0;
  endtask

  task automatic complete(input logic [IDXW-1:0] idx);
    cmp_valid = 1'b1; cmp_idx = idx;
    step();
    cmp_valid = 1'b0;
  endtask

  task automatic expect_issue(input logic [IDXW-1:0] idx, input logic [REGW-1:0] rd, rs1, rs2,
                              input logic [TAGW-1:0] tag);
    exp_q.push_back({idx, rd, rs1, rs2, tag});
  endtask

  // scoreboard: every accepted issue must match the head of the expected queue
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      check("issue_expected", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0)
        check("issue", 64'({out_idx, out_rd, out_rs1, out_rs2, out_tag}), 64'(exp_q.pop_front()));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 8; i++) t[i] = $urandom;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_rd = '0; in_rs1 = '0; in_rs2 = '0;
    in_tag = '0; out_ready = 1'b0; cmp_valid = 1'b0; cmp_idx = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_count", 64'(count), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_err", 64'(err_cmp), 64'd0);
    rst_n = 1'b1;
    step();

    // independent stream
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      expect_issue(IDXW'(i), REGW'(3*i+1), REGW'(3*i+2), REGW'(3*i+3), t[i]);
      insert(REGW'(3*i+1), REGW'(3*i+2), REGW'(3*i+3), t[i]);
    end
    check("s1_count_peak", 64'(count), 64'd3);
    step();
    complete(0);
    check("s1_count_2", 64'(count), 64'd2);
    complete(1);
    complete(2);
    check("s1_count_0", 64'(count), 64'd0);
    check("s1_drain", 64'(exp_q.size()), 64'd0);

    // RAW chain, then x0 case
    expect_issue(0, 5, 1, 2, t[3]);
    insert(5, 1, 2, t[3]);
    insert(6, 5, 0, t[4]);
    step(); step();
    check("raw_withheld", 64'(out_valid), 64'd0);
    complete(0);
    check("raw_release_valid", 64'(out_valid), 64'd1);
    check("raw_release_idx", 64'(out_idx), 64'd1);
    expect_issue(1, 6, 5, 0, t[4]);
    step();
    check("raw_drain", 64'(exp_q.size()), 64'd0);
    complete(1);
    expect_issue(0, 0, 1, 2, t[5]);
    expect_issue(1, 7, 0, 3, t[6]);
    insert(0, 1, 2, t[5]);
    insert(7, 0, 3, t[6]);
    step();
    check("x0_drain", 64'(exp_q.size()), 64'd0);
    complete(0);
    complete(1);
    check("s2_count_0", 64'(count), 64'd0);

    // age ordering: reused slot 1 must wait behind older slot 3
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) insert(REGW'(i+1), 0, 0, t[i]);
    expect_issue(0, 1, 0, 0, t[0]);
    expect_issue(1, 2, 0, 0, t[1]);
    out_ready = 1'b1;
    step(); step();
    out_ready = 1'b0;
    complete(1);
    insert(9, 10, 11, t[7]);
    check("age_count", 64'(count), 64'd4);
    expect_issue(2, 3, 0, 0, t[2]);
    expect_issue(3, 4, 0, 0, t[3]);
    expect_issue(1, 9, 10, 11, t[7]);
    out_ready = 1'b1;
    step(); step(); step();
    check("age_drain", 64'(exp_q.size()), 64'd0);
    complete(0); complete(2); complete(3); complete(1);
    check("s3_count_0", 64'(count), 64'd0);

    // backpressure stability, then fill to full
    out_ready = 1'b0;
    insert(1, 0, 0, t[0]);
    insert(2, 0, 0, t[1]);
    for (int c = 0; c < 5; c++) begin
      check("bp_valid", 64'(out_valid), 64'd1);
      check("bp_idx", 64'(out_idx), 64'd0);
      check("bp_rd", 64'(out_rd), 64'd1);
      check("bp_tag", 64'(out_tag), 64'(t[0]));
      step();
    end
    for (int i = 2; i < BS; i++) insert(0, 0, 0, TAGW'(i));
    check("full_count", 64'(count), 64'(BS));
    check("full_in_ready", 64'(in_ready), 64'd0);
    insert(3, 0, 0, 32'hdead);
    check("full_ignored", 64'(count), 64'(BS));
    check("full_hold_idx", 64'(out_idx), 64'd0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("full_flush_count", 64'(count), 64'd0);
    check("full_flush_valid", 64'(out_valid), 64'd0);

    // same-cycle completion, insert and issue
    out_ready = 1'b1;
    expect_issue(0, 3, 1, 2, t[0]);
    insert(3, 1, 2, t[0]);
    step();
    out_ready = 1'b0;
    insert(4, 0, 0, t[1]);
    check("sc_count_before", 64'(count), 64'd2);
    expect_issue(1, 4, 0, 0, t[1]);
    expect_issue(2, 8, 3, 0, t[2]);
    cmp_valid = 1'b1; cmp_idx = 0;
    in_valid = 1'b1; in_rd = 8; in_rs1 = 3; in_rs2 = 0; in_tag = t[2];
    out_ready = 1'b1;
    step();
    cmp_valid = 1'b0; in_valid = 1'b0;
    check("sc_count_after", 64'(count), 64'd2);
    step();
    check("sc_drain", 64'(exp_q.size()), 64'd0);
    complete(1); complete(2);
    check("s5_count_0", 64'(count), 64'd0);

    // completion errors and flush
    out_ready = 1'b0;
    complete(5);
    check("err_free_pulse", 64'(err_cmp), 64'd1);
    check("err_free_count", 64'(count), 64'd0);
    step();
    check("err_clear", 64'(err_cmp), 64'd0);
    insert(1, 0, 0, t[3]);
    complete(0);
    check("err_wait_pulse", 64'(err_cmp), 64'd1);
    check("err_wait_count", 64'(count), 64'd1);
    check("err_wait_valid", 64'(out_valid), 64'd1);
    for (int i = 1; i < 10; i++) insert(REGW'(i), 0, 0, TAGW'(i));
    check("fl_count_10", 64'(count), 64'd10);
    flush = 1'b1; cmp_valid = 1'b1; cmp_idx = 20;
    step();
    flush = 1'b0; cmp_valid = 1'b0;
    check("fl_count", 64'(count), 64'd0);
    check("fl_valid", 64'(out_valid), 64'd0);
    check("fl_no_err", 64'(err_cmp), 64'd0);
    check("fl_in_ready", 64'(in_ready), 64'd1);

    // asynchronous reset mid-stream
    out_ready = 1'b1;
    expect_issue(0, 1, 0, 0, t[4]);
    insert(1, 0, 0, t[4]);
    insert(2, 1, 0, t[5]);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_count", 64'(count), 64'd0);
    check("rst_mid_in_ready", 64'(in_ready), 64'd1);
    check("rst_mid_valid", 64'(out_valid), 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    step();
    check("rst_mid_after", 64'(count), 64'd0);
    check("final_drain", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
